// File: rtl/seq_mult_param.sv
// Sequential shift-and-add multiplier: one adder iterated over WIDTH cycles,
// runtime signed/unsigned mode, valid/ready handshakes on operands and result.
module seq_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH:0]     acc;
  logic [2*WIDTH:0]     acc_nxt;
  logic [WIDTH:0]       upper_add;
  logic [CW-1:0]        count;
  logic                 neg;
  logic                 last;

  // |-2^(WIDTH-1)| still fits in WIDTH unsigned bits, so no overflow here.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] m,
                                                    input logic n);
    return n ? (~m + (2*WIDTH)'(1)) : m;
  endfunction

  // Low WIDTH bits of acc hold the remaining multiplier; upper bits accumulate.
  always_comb begin
    upper_add = acc[0] ? (acc[2*WIDTH:WIDTH] + {1'b0, mcand}) : acc[2*WIDTH:WIDTH];
    acc_nxt   = {1'b0, upper_add, acc[WIDTH-1:1]};
    last      = (count == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CALC;
      CALC:    if (last)     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      acc     <= '0;
      count   <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mcand <= magnitude(a, signed_mode);
          acc   <= {{(WIDTH+1){1'b0}}, magnitude(b, signed_mode)};
          neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          count <= '0;
        end
        CALC: begin
          acc   <= acc_nxt;
          count <= count + CW'(1);
          if (last) product <= apply_sign(acc_nxt[2*WIDTH-1:0], neg);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param (WIDTH=8): latency, signed/unsigned results,
// backpressure, asynchronous reset and a long run against a behavioural product.
module tb_seq_mult_param;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a, b;
  logic           signed_mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int compared = 0;
  int mismatched = 0;

  seq_mult_param #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
    .out_ready(out_ready), .product(product), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*W-1:0] ref_mult(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic s);
    logic signed [2*W-1:0] sp;
    if (s) begin
      sp = $signed(x) * $signed(y);
      return sp;
    end
    return {{W{1'b0}}, x} * {{W{1'b0}}, y};
  endfunction

  // One complete transaction: accept, latency check, result check, optional stall, consume.
  task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic s, input logic [2*W-1:0] exp, input int stall);
    int n;
    logic ir_low;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    a = x; b = y; signed_mode = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; signed_mode = $urandom;
    ir_low = 1'b1;
    n = 0;
    while (n < 20) begin
      tick(); n++;
      if (in_ready) ir_low = 1'b0;
      if (out_valid) break;
    end
    check({tag, "_latency"}, n, W);
    check({tag, "_inready_low"}, {31'd0, ir_low}, 32'd1);
    check({tag, "_product"}, {16'd0, product}, {16'd0, exp});
    repeat (stall) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_consumed"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic rs;
    logic [2*W-1:0] held;
    logic stable;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b0;
    #12;
    check("reset_outputs", {13'd0, in_ready, out_valid, busy, product}, {13'd0, 3'b100, 16'h0000});
    rst_n = 1'b1;
    tick();

    do_op("u7x5",       8'd7,   8'd5,   1'b0, 16'h0023, 0);
    do_op("uFFxFF",     8'hFF,  8'hFF,  1'b0, 16'hFE01, 0);
    do_op("sm1xm1",     8'hFF,  8'hFF,  1'b1, 16'h0001, 0);
    do_op("sm3x5",      8'hFD,  8'd5,   1'b1, 16'hFFF1, 0);
    do_op("s80x80",     8'h80,  8'h80,  1'b1, 16'h4000, 0);
    do_op("s80x01",     8'h80,  8'h01,  1'b1, 16'hFF80, 0);
    do_op("u80x80",     8'h80,  8'h80,  1'b0, 16'h4000, 2);
    do_op("szero_neg",  8'h00,  8'h85,  1'b1, 16'h0000, 0);
    do_op("u0xFF",      8'h00,  8'hFF,  1'b0, 16'h0000, 1);

    // Backpressure: hold the result for 20 cycles while new operands are offered.
    a = 8'd12; b = 8'd11; signed_mode = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (W) tick();
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    held = product;
    check("bp_product", {16'd0, held}, 32'h0000_0084);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin a = 8'd9; b = 8'd9; in_valid = 1'b1; end
      if (i == 6) in_valid = 1'b0;
      tick();
      if (product !== held || !out_valid || in_ready || !busy) stable = 1'b0;
    end
    check("bp_stable", {31'd0, stable}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_consumed", {30'd0, out_valid, in_ready}, 32'd1);
    check("bp_product_kept", {16'd0, product}, 32'h0000_0084);

    // Asynchronous reset four cycles into CALC.
    a = 8'h11; b = 8'h22; signed_mode = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {13'd0, in_ready, out_valid, busy, product}, {13'd0, 3'b100, 16'h0000});
    tick();
    #3 rst_n = 1'b1;
    tick();
    do_op("post_reset", 8'd3, 8'd4, 1'b0, 16'h000C, 0);

    for (int k = 0; k < 500; k++) begin
      ra = $urandom; rb = $urandom; rs = $urandom;
      do_op("rand", ra, rb, rs, ref_mult(ra, rb, rs), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
